capture_engine: RTL and testbench

Sampling and trigger back-end of the logic analyzer; consumes the settings produced by `main_controller` (`PRESCALING_FACTOR`, `TRIGGER_KIND`) and applies them to the 16 probe inputs. On `arm` it samples the probes at the prescaled rate, keeps a pre-trigger history, detects the programmed per-channel trigger, records the post-trigger window into an internal buffer and then exposes the buffer on a synchronous read port for the display/upload path.

---
 rtl/la_pkg.sv | 39 +++
 rtl/capture_engine_if.sv | 39 +++
 rtl/sample_ram.sv | 42 ++++
 rtl/capture_engine.sv | 180 ++++++++++++++++++
 tb/tb_capture_engine.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/la_pkg.sv
// ----------------------------------------------------------------------------
// la_pkg
// Types and constants shared by the logic-analyzer blocks.
//   trig_kind_e  - per-channel trigger mode, 2-bit encoding
//   cap_state_e  - capture engine state
//   chan_hit()   - evaluates one channel's trigger mode on two
//                  consecutive samples
// ----------------------------------------------------------------------------
package la_pkg;

    localparam int NUM_CHANNELS    = 16;
    localparam int PRESCALER_WIDTH = 29;

    typedef enum logic [1:0] {
        TRIG_NONE   = 2'b00,  // channel ignored by the trigger
        TRIG_RISE   = 2'b01,
        TRIG_FALL   = 2'b10,
        TRIG_EITHER = 2'b11
    } trig_kind_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_WAIT,
        ST_POST,
        ST_DONE
    } cap_state_e;

    // True when the transition prev -> cur matches the channel's mode.
    function automatic logic chan_hit(trig_kind_e kind, logic prev, logic cur);
        case (kind)
            TRIG_RISE:   return !prev && cur;
            TRIG_FALL:   return prev && !cur;
            TRIG_EITHER: return prev ^ cur;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/capture_engine_if.sv
// ----------------------------------------------------------------------------
// capture_engine_if
// Control, probe and readout signals of the capture engine.
//   arm               - single-cycle start pulse
//   PRESCALING_FACTOR - clocks per sample (0 behaves as 1)
//   TRIGGER_KIND      - per-channel trigger mode
//   probe             - asynchronous probe lines
//   rd_addr / rd_data - readout port, 0 = oldest sample, 1-cycle latency
//   busy / triggered / done - capture status
// master: the controller side; slave: the capture engine.
// ----------------------------------------------------------------------------
interface capture_engine_if
    import la_pkg::*;
#(
    parameter int DEPTH = 256
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic                       arm;
    logic [PRESCALER_WIDTH-1:0] PRESCALING_FACTOR;
    trig_kind_e                 TRIGGER_KIND [NUM_CHANNELS-1:0];
    logic [NUM_CHANNELS-1:0]    probe;
    logic [ADDR_W-1:0]          rd_addr;
    logic [NUM_CHANNELS-1:0]    rd_data;
    logic                       busy;
    logic                       triggered;
    logic                       done;

    modport master (
        output arm, PRESCALING_FACTOR, TRIGGER_KIND, probe, rd_addr,
        input  rd_data, busy, triggered, done
    );

    modport slave (
        input  arm, PRESCALING_FACTOR, TRIGGER_KIND, probe, rd_addr,
        output rd_data, busy, triggered, done
    );

endinterface

// File: rtl/sample_ram.sv
// ----------------------------------------------------------------------------
// sample_ram
// Simple dual-port sample store, DEPTH x WIDTH.
//   clk, rst          - clock, async active-high reset (read register only)
//   wr_en/wr_addr/wr_data - write port
//   rd_addr / rd_data - registered read port, 1-cycle latency
// ----------------------------------------------------------------------------
module sample_ram
    import la_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int WIDTH = NUM_CHANNELS,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto block RAM; its contents
    // are meaningless until written by a capture.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/capture_engine.sv
// ----------------------------------------------------------------------------
// capture_engine
// Sampling and trigger back-end of the logic analyzer. On arm it samples the
// synchronized probes at the prescaled rate, keeps PRE_SAMPLES of history,
// waits for the programmed trigger, records the post-trigger window and then
// serves the buffer oldest-first on the read port.
//   clk, rst - clock, async active-high reset
//   bus      - capture_engine_if.slave (arm, settings, probes, readout, status)
// ----------------------------------------------------------------------------
module capture_engine
    import la_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int PRE_SAMPLES = 64
) (
    input  logic               clk,
    input  logic               rst,
    capture_engine_if.slave    bus
);

    localparam int AW           = $clog2(DEPTH);
    localparam int CW           = AW + 1;
    localparam int PW           = PRESCALER_WIDTH;
    localparam int POST_SAMPLES = DEPTH - PRE_SAMPLES;

    cap_state_e              state, state_nxt;
    logic [NUM_CHANNELS-1:0] sync_meta, sync_q, prev_sample;
    logic [PW-1:0]           factor_q, presc_cnt;
    trig_kind_e              kind_q [NUM_CHANNELS-1:0];
    logic [AW-1:0]           wr_ptr, trig_ptr, rd_phys;
    logic [CW-1:0]           fill_cnt;   // samples written in PRE or POST
    logic                    triggered_q;

    logic busy_int, arm_ok, tick, wr_en;
    logic trig_hit, any_armed, trig_cond;

    assign busy_int = (state == ST_PRE) || (state == ST_WAIT) || (state == ST_POST);
    assign arm_ok   = bus.arm && ((state == ST_IDLE) || (state == ST_DONE));
    assign tick     = busy_int && (presc_cnt == '0);

    // Two-flop probe synchronizer.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the values from before the edge, making the two stages a true shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= bus.probe;
            sync_q    <= sync_meta;
        end
    end

    // Trigger detector. With every channel at don't-care the condition is
    // forced true so the first WAIT tick fires.
    always_comb begin
        trig_hit  = 1'b0;
        any_armed = 1'b0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (kind_q[ch] != TRIG_NONE) begin
                any_armed = 1'b1;
            end
            if (chan_hit(kind_q[ch], prev_sample[ch], sync_q[ch])) begin
                trig_hit = 1'b1;
            end
        end
        trig_cond = any_armed ? trig_hit : 1'b1;
    end

    // FSM: state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state and write strobe.
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arm_ok) state_nxt = ST_PRE;
            end
            ST_PRE: begin
                if (tick) begin
                    wr_en = 1'b1;
                    if (fill_cnt == CW'(PRE_SAMPLES - 1)) state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tick) begin
                    wr_en = 1'b1;
                    if (trig_cond) state_nxt = (POST_SAMPLES == 1) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                if (tick) begin
                    wr_en = 1'b1;
                    if (fill_cnt == CW'(POST_SAMPLES - 1)) state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (arm_ok) state_nxt = ST_PRE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Settings latch, prescaler, pointers and trigger bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            factor_q    <= '0;
            presc_cnt   <= '0;
            wr_ptr      <= '0;
            trig_ptr    <= '0;
            fill_cnt    <= '0;
            prev_sample <= '0;
            triggered_q <= 1'b0;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                kind_q[ch] <= TRIG_NONE;
            end
        end else if (arm_ok) begin
            factor_q    <= (bus.PRESCALING_FACTOR == '0) ? PW'(1) : bus.PRESCALING_FACTOR;
            kind_q      <= bus.TRIGGER_KIND;
            presc_cnt   <= '0;
            wr_ptr      <= '0;
            fill_cnt    <= '0;
            triggered_q <= 1'b0;
        end else if (busy_int) begin
            presc_cnt <= (presc_cnt == factor_q - PW'(1)) ? '0 : presc_cnt + PW'(1);
            if (tick) begin
                prev_sample <= sync_q;
                wr_ptr      <= wr_ptr + 1'b1;
                case (state)
                    ST_PRE: begin
                        fill_cnt <= (fill_cnt == CW'(PRE_SAMPLES - 1)) ? '0 : fill_cnt + 1'b1;
                    end
                    ST_WAIT: begin
                        if (trig_cond) begin
                            trig_ptr    <= wr_ptr;
                            triggered_q <= 1'b1;
                            fill_cnt    <= CW'(1);  // trigger sample opens the post window
                        end
                    end
                    ST_POST: begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Logical read index 0 is the oldest kept sample, PRE_SAMPLES before
    // the trigger; the subtraction wraps modulo DEPTH.
    assign rd_phys = trig_ptr - AW'(PRE_SAMPLES) + bus.rd_addr;

    sample_ram #(
        .DEPTH (DEPTH),
        .WIDTH (NUM_CHANNELS)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (sync_q),
        .rd_addr (rd_phys),
        .rd_data (bus.rd_data)
    );

    assign bus.busy      = busy_int;
    assign bus.triggered = triggered_q;
    assign bus.done      = (state == ST_DONE);

endmodule

// File: tb/tb_capture_engine.sv
// ----------------------------------------------------------------------------
// tb_capture_engine
// Directed self-checking bench for capture_engine (DEPTH 256, PRE_SAMPLES 64).
// Timing model used for expected values: with arm sampled at edge e0, sample
// tick m writes at edge e(1 + f*m) (f = factor, 0 treated as 1), the value
// written at edge ej is the probe value driven two edges earlier, and done is
// visible after the last write at tick m_last, i.e. 1 + f*m_last edges after
// the arm edge.
// ----------------------------------------------------------------------------
module tb_capture_engine;
    import la_pkg::*;

    localparam int DEPTH = 256;
    localparam int PRE   = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    capture_engine_if #(.DEPTH(DEPTH)) bus ();

    capture_engine #(
        .DEPTH       (DEPTH),
        .PRE_SAMPLES (PRE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    logic count_en = 1'b0;

    typedef struct {
        logic [28:0] factor;
        int          lat;     // edges from arm edge to done visible
        logic [7:0]  addr;    // read index checked
        int          off;     // expected rd_data = p0 + off
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One clock; probes count up by one per clock when count_en is set.
    task automatic step();
        @(negedge clk);
        if (count_en) bus.probe = bus.probe + 16'd1;
    endtask

    task automatic set_kind_all(input trig_kind_e k);
        for (int i = 0; i < NUM_CHANNELS; i++) bus.TRIGGER_KIND[i] = k;
    endtask

    // Returns p0, the probe value present in the cycle ending at the arm edge.
    task automatic do_arm(output logic [15:0] p0);
        step();
        bus.arm = 1'b1;
        p0 = bus.probe;
        step();
        bus.arm = 1'b0;
    endtask

    // start = edges after the arm edge already elapsed; lat = -1 on timeout.
    task automatic wait_done(input int limit, input int start, output int lat);
        int n;
        n = 0;
        while (!bus.done && n < limit) begin
            step();
            n++;
        end
        lat = bus.done ? start + n : -1;
    endtask

    task automatic read(input logic [7:0] addr, output logic [15:0] data);
        bus.rd_addr = addr;
        step();
        data = bus.rd_data;
    endtask

    initial begin
        logic [15:0] p0, d, exp_d;
        int          lat, bad;

        vecs[0] = '{29'd1, 256, 8'd64,  63};
        vecs[1] = '{29'd0, 256, 8'd64,  63};
        vecs[2] = '{29'd1, 256, 8'd0,   -1};
        vecs[3] = '{29'd0, 256, 8'd255, 254};
        vecs[4] = '{29'd3, 766, 8'd64,  191};
        vecs[5] = '{29'd3, 766, 8'd1,   2};

        rst                   = 1'b1;
        bus.arm               = 1'b0;
        bus.probe             = '0;
        bus.rd_addr           = '0;
        bus.PRESCALING_FACTOR = 29'd1;
        set_kind_all(TRIG_NONE);
        step();
        step();
        check("reset_busy",      bus.busy,      1'b0);
        check("reset_triggered", bus.triggered, 1'b0);
        check("reset_done",      bus.done,      1'b0);
        check("reset_rd_data",   bus.rd_data,   16'h0000);
        rst = 1'b0;
        step();

        // Table: free-running trigger (all don't care) at several factors.
        for (int i = 0; i < 6; i++) begin
            bus.PRESCALING_FACTOR = vecs[i].factor;
            set_kind_all(TRIG_NONE);
            count_en = 1'b1;
            do_arm(p0);
            check($sformatf("v%0d_busy_after_arm", i), bus.busy, 1'b1);
            wait_done(5000, 0, lat);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_triggered", i), bus.triggered, 1'b1);
            check($sformatf("v%0d_busy_done", i), bus.busy, 1'b0);
            read(vecs[i].addr, d);
            exp_d = p0 + 16'(vecs[i].off);
            check($sformatf("v%0d_rd", i), d, exp_d);
        end
        count_en = 1'b0;

        // Factor 5, ch3 rising; arm and setting changes during PRE must not matter.
        bus.probe = '0;
        bus.PRESCALING_FACTOR = 29'd5;
        set_kind_all(TRIG_NONE);
        bus.TRIGGER_KIND[3] = TRIG_RISE;
        do_arm(p0);
        repeat (99) step();
        bus.PRESCALING_FACTOR = 29'd1;
        set_kind_all(TRIG_NONE);
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0;
        check("f5_busy_mid_pre", bus.busy, 1'b1);
        repeat (299) step();
        check("f5_not_triggered_yet", bus.triggered, 1'b0);
        check("f5_busy_waiting", bus.busy, 1'b1);
        bus.probe[3] = 1'b1;
        // trigger at tick 81 (edge 406), last write at tick 272
        wait_done(5000, 399, lat);
        check("f5_latency", lat, 1 + 5 * (81 + 191));
        check("f5_triggered", bus.triggered, 1'b1);
        read(8'd63, d);
        check("f5_rd63", d, 16'h0000);
        read(8'd64, d);
        check("f5_rd64", d, 16'h0008);

        // ch0 falling, toggled only during PRE: must keep waiting.
        bus.probe = 16'h0001;
        bus.PRESCALING_FACTOR = 29'd1;
        set_kind_all(TRIG_NONE);
        bus.TRIGGER_KIND[0] = TRIG_FALL;
        do_arm(p0);
        for (int k = 0; k < 40; k++) begin
            step();
            bus.probe[0] = ~bus.probe[0];
        end
        repeat (400) step();
        check("fall_busy_held",    bus.busy,      1'b1);
        check("fall_no_trigger",   bus.triggered, 1'b0);
        check("fall_not_done",     bus.done,      1'b0);
        bus.probe[0] = 1'b0;
        // trigger at tick 442, last write at tick 633
        wait_done(5000, 440, lat);
        check("fall_latency", lat, 1 + 442 + 191);
        read(8'd63, d);
        check("fall_rd63", d, 16'h0001);
        read(8'd64, d);
        check("fall_rd64", d, 16'h0000);

        // Counter on probes, ch10 rising fires at sample 1024: forces pointer wrap.
        bus.probe = '0;
        set_kind_all(TRIG_NONE);
        bus.TRIGGER_KIND[10] = TRIG_RISE;
        count_en = 1'b1;
        do_arm(p0);
        wait_done(5000, 0, lat);
        check("wrap_latency", lat, 1 + (1025 - int'(p0)) + 191);
        bad = 0;
        for (int r = 0; r < DEPTH; r++) begin
            read(8'(r), d);
            if (d != 16'(960 + r)) bad++;
        end
        check("wrap_contiguous_errors", bad, 0);
        read(8'd0, d);
        check("wrap_rd0", d, 16'd960);
        read(8'd64, d);
        check("wrap_rd64", d, 16'd1024);

        // Reset during POST, arm coinciding with reset, then a clean capture.
        set_kind_all(TRIG_NONE);
        do_arm(p0);
        repeat (100) step();
        check("post_busy", bus.busy, 1'b1);
        check("post_triggered", bus.triggered, 1'b1);
        rst = 1'b1;
        bus.arm = 1'b1;
        step();
        check("rst_busy",      bus.busy,      1'b0);
        check("rst_triggered", bus.triggered, 1'b0);
        check("rst_done",      bus.done,      1'b0);
        check("rst_rd_data",   bus.rd_data,   16'h0000);
        rst = 1'b0;
        bus.arm = 1'b0;
        step();
        check("rst_arm_ignored", bus.busy, 1'b0);
        do_arm(p0);
        wait_done(5000, 0, lat);
        check("rearm_latency", lat, 256);
        check("rearm_triggered", bus.triggered, 1'b1);
        read(8'd64, d);
        check("rearm_rd64", d, p0 + 16'd63);
        count_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
